// File: rtl/load_mshr_file.sv
// Load-miss MSHR file: allocates/merges dcache load misses, issues one
// memory read per entry, matches tagged responses and broadcasts refills.
module load_mshr_file #(
    parameter int NUM_MSHR = 4,
    parameter int IDX_W    = $clog2(NUM_MSHR),
    parameter int TAG_W    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             miss_req_valid,
    input  logic [31:0]      miss_req_addr,
    output logic             miss_req_ack,
    output logic [IDX_W-1:0] miss_mshr_idx,
    output logic             mshr_full,
    output logic             mem_req_valid,
    output logic [31:0]      mem_req_addr,
    input  logic [TAG_W-1:0] mem_req_tag,
    input  logic [TAG_W-1:0] mem_resp_tag,
    input  logic [63:0]      mem_resp_data,
    output logic             refill_valid,
    output logic [IDX_W-1:0] refill_mshr_idx,
    output logic [31:0]      refill_addr,
    output logic [63:0]      refill_data
);

    typedef enum logic [1:0] {
        ST_INVALID,
        ST_PENDING,
        ST_ISSUED,
        ST_REFILL
    } mshr_state_e;

    mshr_state_e      state_q [NUM_MSHR];
    mshr_state_e      state_d [NUM_MSHR];
    logic [28:0]      block_q [NUM_MSHR];
    logic [28:0]      block_d [NUM_MSHR];
    logic [TAG_W-1:0] tag_q   [NUM_MSHR];
    logic [TAG_W-1:0] tag_d   [NUM_MSHR];
    logic [63:0]      data_q  [NUM_MSHR];
    logic [63:0]      data_d  [NUM_MSHR];

    logic [NUM_MSHR-1:0] resp_hit;
    logic             merge_found, alloc_found, pend_found, refill_found;
    logic [IDX_W-1:0] merge_idx, alloc_idx, pend_idx, refill_idx;
    logic             ack;
    logic             issue_go;
    logic             addr_lsb_unused;

    // Byte offset inside the block does not affect block tracking.
    assign addr_lsb_unused = ^miss_req_addr[2:0];

    // Entry selection, outputs and next-state for every entry.
    always_comb begin
        resp_hit     = '0;
        merge_found  = 1'b0;
        merge_idx    = '0;
        alloc_found  = 1'b0;
        alloc_idx    = '0;
        pend_found   = 1'b0;
        pend_idx     = '0;
        refill_found = 1'b0;
        refill_idx   = '0;

        for (int i = 0; i < NUM_MSHR; i++) begin
            resp_hit[i] = (mem_resp_tag != '0) &&
                          (state_q[i] == ST_ISSUED) &&
                          (tag_q[i] == mem_resp_tag);
        end

        for (int i = 0; i < NUM_MSHR; i++) begin
            if (!merge_found && miss_req_valid && !resp_hit[i] &&
                (state_q[i] == ST_PENDING || state_q[i] == ST_ISSUED) &&
                block_q[i] == miss_req_addr[31:3]) begin
                merge_found = 1'b1;
                merge_idx   = IDX_W'(i);
            end
            if (!alloc_found && state_q[i] == ST_INVALID) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
            if (!pend_found && state_q[i] == ST_PENDING) begin
                pend_found = 1'b1;
                pend_idx   = IDX_W'(i);
            end
            if (!refill_found && state_q[i] == ST_REFILL) begin
                refill_found = 1'b1;
                refill_idx   = IDX_W'(i);
            end
        end

        ack      = !reset && miss_req_valid && (merge_found || alloc_found);
        issue_go = !reset && pend_found && (mem_req_tag != '0);

        miss_req_ack    = ack;
        miss_mshr_idx   = '0;
        if (ack) miss_mshr_idx = merge_found ? merge_idx : alloc_idx;
        mshr_full       = !reset && !alloc_found;
        mem_req_valid   = !reset && pend_found;
        mem_req_addr    = '0;
        if (mem_req_valid) mem_req_addr = {block_q[pend_idx], 3'b000};
        refill_valid    = !reset && refill_found;
        refill_mshr_idx = '0;
        refill_addr     = '0;
        refill_data     = '0;
        if (refill_valid) begin
            refill_mshr_idx = refill_idx;
            refill_addr     = {block_q[refill_idx], 3'b000};
            refill_data     = data_q[refill_idx];
        end

        for (int i = 0; i < NUM_MSHR; i++) begin
            state_d[i] = state_q[i];
            block_d[i] = block_q[i];
            tag_d[i]   = tag_q[i];
            data_d[i]  = data_q[i];
            if (state_q[i] == ST_REFILL) begin
                state_d[i] = ST_INVALID;
                tag_d[i]   = '0;
            end
            if (resp_hit[i]) begin
                state_d[i] = ST_REFILL;
                data_d[i]  = mem_resp_data;
            end
            if (issue_go && pend_idx == IDX_W'(i)) begin
                state_d[i] = ST_ISSUED;
                tag_d[i]   = mem_req_tag;
            end
            if (ack && !merge_found && alloc_idx == IDX_W'(i)) begin
                state_d[i] = ST_PENDING;
                block_d[i] = miss_req_addr[31:3];
            end
        end
    end

    // Entry registers; reset drops all in-flight state.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_MSHR; i++) begin
                state_q[i] <= ST_INVALID;
                block_q[i] <= '0;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_MSHR; i++) begin
                state_q[i] <= state_d[i];
                block_q[i] <= block_d[i];
                tag_q[i]   <= tag_d[i];
                data_q[i]  <= data_d[i];
            end
        end
    end

endmodule

// File: tb/tb_load_mshr_file.sv
// Bench for load_mshr_file: directed vector table, hand sequences,
// then random traffic against an abstract slot model.
module tb_load_mshr_file;

    logic        clock;
    logic        reset;
    logic        miss_req_valid;
    logic [31:0] miss_req_addr;
    logic        miss_req_ack;
    logic [1:0]  miss_mshr_idx;
    logic        mshr_full;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic [3:0]  mem_req_tag;
    logic [3:0]  mem_resp_tag;
    logic [63:0] mem_resp_data;
    logic        refill_valid;
    logic [1:0]  refill_mshr_idx;
    logic [31:0] refill_addr;
    logic [63:0] refill_data;

    load_mshr_file dut (
        .clock(clock),
        .reset(reset),
        .miss_req_valid(miss_req_valid),
        .miss_req_addr(miss_req_addr),
        .miss_req_ack(miss_req_ack),
        .miss_mshr_idx(miss_mshr_idx),
        .mshr_full(mshr_full),
        .mem_req_valid(mem_req_valid),
        .mem_req_addr(mem_req_addr),
        .mem_req_tag(mem_req_tag),
        .mem_resp_tag(mem_resp_tag),
        .mem_resp_data(mem_resp_data),
        .refill_valid(refill_valid),
        .refill_mshr_idx(refill_mshr_idx),
        .refill_addr(refill_addr),
        .refill_data(refill_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        mv;
        logic [31:0] ma;
        logic [3:0]  stag;
        logic [3:0]  rtag;
        logic [63:0] rdat;
        logic        ack;
        logic [1:0]  idx;
        logic        full;
        logic        mqv;
        logic [31:0] mqa;
        logic        rv;
        logic [1:0]  ridx;
        logic [31:0] raddr;
        logic [63:0] rd;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [63:0] DA = 64'h11223344_AABBCCDD;
    localparam logic [63:0] D1 = 64'h01020304_05060708;
    localparam logic [63:0] D2 = 64'hCAFEF00D_DEADBEEF;
    localparam logic [63:0] D3 = 64'h13579BDF_2468ACE0;
    localparam logic [63:0] D4 = 64'hFFFF0000_0000FFFF;
    localparam logic [63:0] D5 = 64'h0F0F0F0F_F0F0F0F0;

    function automatic vec_t mk(
        logic rst, logic mv, logic [31:0] ma, logic [3:0] stag,
        logic [3:0] rtag, logic [63:0] rdat,
        logic ack, logic [1:0] idx, logic full,
        logic mqv, logic [31:0] mqa,
        logic rv, logic [1:0] ridx, logic [31:0] raddr, logic [63:0] rd);
        vec_t v;
        v.rst = rst; v.mv = mv; v.ma = ma; v.stag = stag;
        v.rtag = rtag; v.rdat = rdat;
        v.ack = ack; v.idx = idx; v.full = full;
        v.mqv = mqv; v.mqa = mqa;
        v.rv = rv; v.ridx = ridx; v.raddr = raddr; v.rd = rd;
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        @(negedge clock);
        reset          = v.rst;
        miss_req_valid = v.mv;
        miss_req_addr  = v.ma;
        mem_req_tag    = v.stag;
        mem_resp_tag   = v.rtag;
        mem_resp_data  = v.rdat;
        #1;
    endtask

    task automatic check_outs(string ctx, vec_t v);
        chk({ctx, " ack"},   64'(miss_req_ack),    64'(v.ack));
        chk({ctx, " idx"},   64'(miss_mshr_idx),   64'(v.idx));
        chk({ctx, " full"},  64'(mshr_full),       64'(v.full));
        chk({ctx, " mqv"},   64'(mem_req_valid),   64'(v.mqv));
        chk({ctx, " mqa"},   64'(mem_req_addr),    64'(v.mqa));
        chk({ctx, " rv"},    64'(refill_valid),    64'(v.rv));
        chk({ctx, " ridx"},  64'(refill_mshr_idx), 64'(v.ridx));
        chk({ctx, " raddr"}, 64'(refill_addr),     64'(v.raddr));
        chk({ctx, " rdata"}, refill_data,          v.rd);
    endtask

    // Abstract model: slot kinds and payloads.
    localparam int FREE = 0;
    localparam int WAIT = 1;
    localparam int OUT  = 2;
    localparam int DONE = 3;
    int          m_st  [4];
    logic [28:0] m_blk [4];
    logic [3:0]  m_tg  [4];
    logic [63:0] m_dat [4];

    function automatic vec_t model_step(vec_t in);
        vec_t e = in;
        int hit = -1, tgt = -1, fr = -1, wt = -1, dn = -1;
        e.ack = 0; e.idx = 0; e.full = 0; e.mqv = 0; e.mqa = 0;
        e.rv = 0; e.ridx = 0; e.raddr = 0; e.rd = 0;
        if (in.rst) begin
            for (int j = 0; j < 4; j++) m_st[j] = FREE;
            return e;
        end
        for (int j = 0; j < 4; j++) begin
            if (in.rtag != 0 && m_st[j] == OUT && m_tg[j] == in.rtag)
                hit = j;
        end
        for (int j = 0; j < 4; j++) begin
            if (tgt < 0 && in.mv && j != hit &&
                (m_st[j] == WAIT || m_st[j] == OUT) &&
                m_blk[j] == in.ma[31:3]) tgt = j;
            if (fr < 0 && m_st[j] == FREE) fr = j;
            if (wt < 0 && m_st[j] == WAIT) wt = j;
            if (dn < 0 && m_st[j] == DONE) dn = j;
        end
        e.ack  = in.mv && (tgt >= 0 || fr >= 0);
        e.idx  = !e.ack ? 2'd0 : (tgt >= 0 ? 2'(tgt) : 2'(fr));
        e.full = (fr < 0);
        if (wt >= 0) begin
            e.mqv = 1;
            e.mqa = {m_blk[wt], 3'b000};
        end
        if (dn >= 0) begin
            e.rv = 1; e.ridx = 2'(dn);
            e.raddr = {m_blk[dn], 3'b000};
            e.rd = m_dat[dn];
            m_st[dn] = FREE;
        end
        if (hit >= 0) begin
            m_st[hit] = DONE;
            m_dat[hit] = in.rdat;
        end
        if (wt >= 0 && in.stag != 0) begin
            m_st[wt] = OUT;
            m_tg[wt] = in.stag;
        end
        if (e.ack && tgt < 0) begin
            m_st[fr] = WAIT;
            m_blk[fr] = in.ma[31:3];
        end
        return e;
    endfunction

    initial begin
        vec_t v, ex;
        logic [3:0] t;
        int u;
        reset = 1; miss_req_valid = 0; miss_req_addr = 0;
        mem_req_tag = 0; mem_resp_tag = 0; mem_resp_data = 0;

        vecs.push_back(mk(1,1,32'h1004,0,0,0, 0,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,32'h1004,0,0,0, 1,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,3,0,0, 0,0,0,1,32'h1000,0,0,0,0));
        vecs.push_back(mk(0,1,32'h1000,0,0,0, 1,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,3,DA, 0,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,1,0,32'h1000,DA));
        vecs.push_back(mk(0,1,32'h2000,0,0,0, 1,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,32'h3000,5,0,0, 1,1,0,1,32'h2000,0,0,0,0));
        vecs.push_back(mk(0,1,32'h4000,6,0,0, 1,2,0,1,32'h3000,0,0,0,0));
        vecs.push_back(mk(0,1,32'h5000,0,0,0, 1,3,0,1,32'h4000,0,0,0,0));
        vecs.push_back(mk(0,1,32'h6000,0,0,0, 0,0,1,1,32'h4000,0,0,0,0));
        vecs.push_back(mk(0,1,32'h3004,0,0,0, 1,1,1,1,32'h4000,0,0,0,0));
        vecs.push_back(mk(0,1,32'h5000,7,0,0, 1,3,1,1,32'h4000,0,0,0,0));
        vecs.push_back(mk(0,0,0,8,0,0, 0,0,1,1,32'h5000,0,0,0,0));
        vecs.push_back(mk(0,1,32'h2000,0,5,D1, 0,0,1,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,32'h2000,0,6,D2,
                          0,0,1,0,0,1,0,32'h2000,D1));
        vecs.push_back(mk(0,1,32'h3000,0,7,D3,
                          1,0,0,0,0,1,1,32'h3000,D2));
        vecs.push_back(mk(0,1,32'h7000,9,8,D4,
                          1,1,0,1,32'h3000,1,2,32'h4000,D3));
        vecs.push_back(mk(0,0,0,0,0,0,
                          0,0,0,1,32'h7000,1,3,32'h5000,D4));
        vecs.push_back(mk(0,1,32'h3000,0,9,D5,
                          1,2,0,1,32'h7000,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,
                          0,0,0,1,32'h7000,1,0,32'h3000,D5));

        foreach (vecs[k]) begin
            apply(vecs[k]);
            check_outs($sformatf("vec%0d", k), vecs[k]);
        end

        // Issue entry 1 with tag 3, then stall the next request.
        v = mk(0,0,0,3,0,0, 0,0,0,1,32'h7000,0,0,0,0);
        apply(v); check_outs("issue_t3", v);
        for (int k = 0; k < 5; k++) begin
            v = mk(0,0,0,0,0,0, 0,0,0,1,32'h3000,0,0,0,0);
            apply(v); check_outs($sformatf("stall%0d", k), v);
        end
        v = mk(1,1,32'h9000,0,0,0, 0,0,0,0,0,0,0,0,0);
        apply(v); check_outs("in_reset", v);
        v = mk(0,0,0,0,3,DA, 0,0,0,0,0,0,0,0,0);
        apply(v); check_outs("post_reset", v);
        v = mk(0,0,0,0,3,DA, 0,0,0,0,0,0,0,0,0);
        apply(v); check_outs("late_resp", v);
        v = mk(0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0);
        apply(v); check_outs("no_refill", v);

        // Random traffic against the slot model.
        v = mk(1,0,0,0,0,0, 0,0,0,0,0,0,0,0,0);
        ex = model_step(v);
        apply(v); check_outs("rnd_rst", ex);
        for (int c = 0; c < 3000; c++) begin
            v.rst  = ($urandom_range(0, 199) == 0);
            v.mv   = $urandom_range(0, 1) == 1;
            v.ma   = {20'h0, 4'($urandom_range(1, 6)), 8'($urandom)};
            v.stag = 0;
            if ($urandom_range(0, 1) == 1) begin
                t = 4'($urandom_range(1, 15));
                for (int n = 0; n < 16; n++) begin
                    u = 0;
                    for (int j = 0; j < 4; j++)
                        if (m_st[j] == OUT && m_tg[j] == t) u = 1;
                    if (u == 0) break;
                    t = (t == 15) ? 4'd1 : t + 1;
                end
                v.stag = t;
            end
            v.rtag = 0;
            u = $urandom_range(0, 9);
            if (u < 4) begin
                int j = $urandom_range(0, 3);
                if (m_st[j] == OUT) v.rtag = m_tg[j];
            end else if (u == 4) begin
                v.rtag = 4'($urandom_range(1, 15));
            end
            v.rdat = {$urandom, $urandom};
            ex = model_step(v);
            apply(v);
            check_outs($sformatf("rnd%0d", c), ex);
        end

        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_mshr_file.md
Name: load_mshr_file

Overview:
- Miss Status Holding Register file for data-cache load misses.
- Sits between the load FU / dcache miss path and main memory, directly upstream of the load buffer.
- Allocates an MSHR for each missing block and merges secondary misses to the same block.
- Issues one memory request per MSHR, matches tagged memory responses, and broadcasts a one-cycle refill packet {valid, mshr_idx, data}. The load buffer uses this packet to fill pending byte lanes.

Parameters:
- NUM_MSHR, 4, number of MSHR entries.
- IDX_W, $clog2(NUM_MSHR), width of an MSHR index.
- TAG_W, 4, memory transaction tag width; tag 0 means "no tag/no response".

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- miss_req_valid  in  1  load FU reports a dcache miss this cycle.
- miss_req_addr  in  32  byte address of the missing load; block = addr[31:3].
- miss_req_ack  out  1  miss accepted (allocated or merged) this cycle.
- miss_mshr_idx  out  IDX_W  MSHR index the load must wait on; valid when ack=1.
- mshr_full  out  1  no INVALID entry exists (registered-state view).
- mem_req_valid  out  1  memory read request.
- mem_req_addr  out  32  block-aligned address ({block,3'b0}).
- mem_req_tag  in  TAG_W  tag returned by memory; nonzero = request accepted this cycle.
- mem_resp_tag  in  TAG_W  tag of returning data; 0 = none.
- mem_resp_data  in  64  returned 8-byte block.
- refill_valid  out  1  refill broadcast to the load buffer and dcache.
- refill_mshr_idx  out  IDX_W  entry being refilled.
- refill_addr  out  32  block-aligned address of the refill.
- refill_data  out  64  block data; word 0 = bits[31:0], word 1 = bits[63:32].

Behaviour:
- Per-entry state: INVALID, PENDING, ISSUED, REFILL. Each entry also holds block[28:0], tag[TAG_W-1:0] and data[63:0].
- Reset: all entries INVALID, tags 0, data 0.
- Outputs during and immediately after reset: refill_valid=0, mem_req_valid=0, miss_req_ack=0, mshr_full=0.
- A reset asserted mid-transaction drops all in-flight state. Late memory responses after reset are ignored because no entry holds a matching tag.
- Merge (combinational, same cycle):
  - Applies when miss_req_valid is high and an entry in PENDING or ISSUED has a matching block.
  - Exception: the entry is not a merge target if it is ISSUED and its tag equals a nonzero mem_resp_tag this cycle.
  - Result: ack=1, miss_mshr_idx = that entry; no state change.
- Allocate:
  - Applies when there is no merge target and at least one INVALID entry exists.
  - The lowest-index INVALID entry takes the request: ack=1, idx = that entry.
  - Next cycle the entry is PENDING with the block stored.
  - REFILL entries are not allocatable in the same cycle they broadcast.
- Reject: when neither merge nor allocate applies, ack=0 and miss_mshr_idx=0. The load FU retries later.
- Issue:
  - mem_req_valid=1 whenever any entry is PENDING at the start of the cycle.
  - mem_req_addr is the lowest-index PENDING entry's block, shifted left by 3.
  - If mem_req_tag≠0, that entry becomes ISSUED with the stored tag next cycle; otherwise it stays PENDING.
  - An entry allocated in cycle N can issue no earlier than cycle N+1.
- Response:
  - If mem_resp_tag≠0 matches the tag of an ISSUED entry, that entry captures mem_resp_data and becomes REFILL next cycle.
  - A response whose tag matches no ISSUED entry is ignored.
  - Issued tags are unique, so at most one entry matches.
- Refill:
  - Each entry in REFILL drives refill_valid=1, refill_mshr_idx, refill_addr and refill_data for exactly one cycle, then becomes INVALID.
  - Latency: response in cycle N → refill broadcast in cycle N+1 → entry allocatable in cycle N+2.
  - At most one REFILL per cycle, because at most one response arrives per cycle.
- Outputs when refill_valid=0: refill_* = 0.
- mshr_full = no entry INVALID in the current registered state.
- Simultaneous events in one cycle are all legal together and must not interfere:
  - an issue on one entry;
  - a response on another entry;
  - an allocation into a third entry.
- Same-block request while the matching entry receives its response: not merged; a new entry is allocated if one is free, otherwise the request is rejected.

Test Plan:
- Reset, then miss addr 0x1004: ack=1, idx=0 that cycle. Next cycle mem_req_valid=1 with addr 0x1000. Memory returns tag 3 → entry ISSUED.
- With entry 0 ISSUED on block 0x1000, miss addr 0x1000 → ack=1, idx=0, mshr_full unchanged, no new mem_req.
- Entry 0 ISSUED with tag 3, then mem_resp_tag=3 and data=0x11223344_AABBCCDD in cycle N → in N+1, refill_valid=1, idx=0, addr=0x1000, data matches. In N+2 refill_valid=0, and a miss to 0x2000 allocates idx 0.
- Fill all 4 entries with distinct blocks → mshr_full=1. A fifth distinct miss gets ack=0. A miss to an already-tracked block still gets ack=1 with the tracked idx.
- In the same cycle, response tag 3 arrives for entry 0 and a miss to entry 0's block arrives with entry 1 free → ack=1, idx=1 (no merge). Entry 0 refills the next cycle.
- mem_req_tag held at 0 for 5 cycles → entry stays PENDING and mem_req_valid stays 1. Asserting reset mid-wait → all outputs 0 next cycle. A later mem_resp_tag=3 produces no refill.
